// File: rtl/rd_skew_control_pkg.sv
// Shared types and sizing helpers for the skewed systolic read sequencer.
package rd_skew_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Relative-cycle counter must reach WR_LAT+MAX_LEN without wrapping.
  function automatic int cnt_width(input int max_len, input int wr_lat);
    return $clog2(max_len + wr_lat) + 1;
  endfunction

endpackage

// File: rtl/rd_skew_control_lane.sv
// One lane of the diagonal read skew: lane IDX reads during t in [IDX, IDX+len).
module rd_skew_lane
  import rd_skew_control_pkg::*;
#(
  parameter int IDX    = 0,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 5,
  parameter int CNT_W  = cnt_width(16, 17)
) (
  input  logic [CNT_W-1:0]  t_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              stall_i,
  output logic              en_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [CNT_W-1:0] first_t;
  logic [CNT_W-1:0] end_t;
  logic [CNT_W-1:0] offset;

  assign first_t = CNT_W'(IDX);
  assign end_t   = first_t + CNT_W'(len_i);
  assign offset  = t_i - first_t;

  assign en_o   = !stall_i && (t_i >= first_t) && (t_i < end_t);
  // Address wraps modulo 2^ADDR_W by truncation.
  assign addr_o = en_o ? (base_i + ADDR_W'(offset)) : '0;

endmodule

// File: rtl/rd_skew_control.sv
// Tile read sequencer: skews per-lane read enables/addresses diagonally across
// N lanes and gates the downstream writer WR_LAT cycles after the first read.
module rd_skew_control
  import rd_skew_control_pkg::*;
#(
  parameter int N       = 16,
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int WR_LAT  = N + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [$clog2(MAX_LEN):0] len,
  input  logic                    stall,
  output logic [N-1:0]            rd_en,
  output logic [N*ADDR_W-1:0]     rd_addr,
  output logic                    busy,
  output logic                    wr_active,
  output logic                    done
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam int CNT_W = cnt_width(MAX_LEN, WR_LAT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    t_q, t_d, last_t;
  logic                stalled_q, stalled_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d, len_clamped;
  logic [N-1:0]        rd_en_q, rd_en_d;
  logic [N*ADDR_W-1:0] rd_addr_q, rd_addr_d, lane_addr;
  logic                lanes_idle;

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign last_t      = CNT_W'(WR_LAT) + CNT_W'(len_q) - CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (len_clamped == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (!stalled_q && (t_q == last_t)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    wr_active = busy && !stalled_q && (t_q >= CNT_W'(WR_LAT)) && (t_q <= last_t);
  end

  // A stalled cycle does not consume its t; stall is sampled by the edge that
  // opens the cycle it freezes, which keeps rd_en/rd_addr purely registered.
  always_comb begin
    t_d       = t_q;
    stalled_d = 1'b0;
    base_d    = base_q;
    len_d     = len_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = len_clamped;
          t_d    = '0;
        end
      end
      ST_RUN: begin
        t_d       = stalled_q ? t_q : t_q + CNT_W'(1);
        stalled_d = stall && (state_d == ST_RUN);
      end
      default: t_d = '0;
    endcase
  end

  assign lanes_idle = (state_d != ST_RUN) || stalled_d;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    rd_skew_lane #(
      .IDX   (gi),
      .ADDR_W(ADDR_W),
      .LEN_W (LEN_W),
      .CNT_W (CNT_W)
    ) u_lane (
      .t_i    (t_d),
      .base_i (base_d),
      .len_i  (len_d),
      .stall_i(lanes_idle),
      .en_o   (rd_en_d[gi]),
      .addr_o (lane_addr[gi*ADDR_W +: ADDR_W])
    );

    assign rd_addr_d[gi*ADDR_W +: ADDR_W] =
      stalled_d ? rd_addr_q[gi*ADDR_W +: ADDR_W] : lane_addr[gi*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_q       <= '0;
      stalled_q <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      t_q       <= t_d;
      stalled_q <= stalled_d;
      base_q    <= base_d;
      len_q     <= len_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_rd_skew_control.sv
// Directed bench for rd_skew_control (N=4, ADDR_W=8, WR_LAT=5).
module tb_rd_skew_control;

  localparam int N       = 4;
  localparam int ADDR_W  = 8;
  localparam int MAX_LEN = 16;
  localparam int WR_LAT  = 5;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                stall = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [LEN_W-1:0]    len = '0;
  logic [N-1:0]        rd_en;
  logic [N*ADDR_W-1:0] rd_addr;
  logic                busy, wr_active, done;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Nominal rd_en pattern by relative cycle t (base 0x40, len 4).
  logic [3:0] nom_en [12] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8,
                              4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [7:0] wrap_a0 [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  rd_skew_control #(
    .N(N), .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr), .busy(busy),
    .wr_active(wr_active), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge inside relative cycle t=0.
  task automatic start_tile(input logic [7:0] b, input logic [LEN_W-1:0] l, input bit rel_rst);
    @(negedge clk);
    if (rel_rst) reset = 1'b1;
    start = 1'b1; base_addr = b; len = l;
    @(negedge clk);
    start = 1'b0; base_addr = '0; len = '0;
  endtask

  task automatic run_nominal(input string name, input bit inject, input bit rel_rst);
    int dones = 0;
    start_tile(8'h40, 5'd4, rel_rst);
    for (int t = 0; t < 12; t++) begin
      chk($sformatf("%s_en_t%0d", name, t), 32'(rd_en), 32'(nom_en[t]));
      chk($sformatf("%s_busy_t%0d", name, t), 32'(busy), 32'(t <= 8));
      chk($sformatf("%s_wr_t%0d", name, t), 32'(wr_active), 32'(t >= 5 && t <= 8));
      chk($sformatf("%s_done_t%0d", name, t), 32'(done), 32'(t == 9));
      if (t == 3) chk($sformatf("%s_addr_t3", name), rd_addr, 32'h40414243);
      if (done) dones++;
      if (inject && t == 2) begin start = 1'b1; base_addr = 8'h80; len = 5'd4; end
      if (inject && t == 3) begin start = 1'b0; base_addr = '0; len = '0; end
      @(negedge clk);
    end
    chk($sformatf("%s_done_count", name), 32'(dones), 32'd1);
    $display("tile %s base=0x40 len=4 done_pulses=%0d", name, dones);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(wr_active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Start issued on the very edge that first sees reset released.
    run_nominal("nominal", 1'b0, 1'b1);

    // Stall for three cycles beginning at t=2.
    begin
      int t;
      bit stl;
      start_tile(8'h40, 5'd4, 1'b0);
      for (int c = 0; c < 15; c++) begin
        stl = (c >= 2 && c <= 4);
        t = (c < 2) ? c : ((c < 5) ? 2 : c - 3);
        chk($sformatf("stall_en_c%0d", c), 32'(rd_en), stl ? 32'd0 : 32'(nom_en[(t < 12) ? t : 11]));
        chk($sformatf("stall_busy_c%0d", c), 32'(busy), 32'(t <= 8));
        chk($sformatf("stall_wr_c%0d", c), 32'(wr_active), 32'(!stl && t >= 5 && t <= 8));
        chk($sformatf("stall_done_c%0d", c), 32'(done), 32'(c == 12));
        if (c >= 1 && c <= 4) chk($sformatf("stall_addr_c%0d", c), rd_addr, 32'h00004041);
        if (c == 5) chk("stall_addr_resume", rd_addr, 32'h00404142);
        stall = (c >= 1 && c <= 3);
        @(negedge clk);
      end
      $display("tile stall base=0x40 len=4 stall=3");
    end

    // Address wrap on lane 0.
    start_tile(8'hFE, 5'd4, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("wrap_a0_t%0d", c), 32'(rd_addr[7:0]), 32'(wrap_a0[c]));
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    $display("tile wrap base=0xFE len=4");

    // Zero-length tile.
    start_tile(8'h10, 5'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("zero_done_c%0d", c), 32'(done), 32'(c == 0));
      chk($sformatf("zero_busy_c%0d", c), 32'(busy), 32'd0);
      chk($sformatf("zero_en_c%0d", c), 32'(rd_en), 32'd0);
      chk($sformatf("zero_wr_c%0d", c), 32'(wr_active), 32'd0);
      @(negedge clk);
    end
    $display("tile zero base=0x10 len=0");

    // Oversized length clamps to MAX_LEN.
    start_tile(8'h00, 5'd20, 1'b0);
    for (int c = 0; c < 23; c++) begin
      if (c == 15) chk("clamp_en_t15", 32'(rd_en), 32'hF);
      if (c == 16) chk("clamp_en_t16", 32'(rd_en), 32'hE);
      if (c >= 20) chk($sformatf("clamp_done_c%0d", c), 32'(done), 32'(c == 21));
      if (c == 20 || c == 21) chk($sformatf("clamp_busy_c%0d", c), 32'(busy), 32'(c == 20));
      @(negedge clk);
    end
    $display("tile clamp base=0x00 len=20");

    // Reset mid-tile at t=3.
    start_tile(8'h40, 5'd4, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_rd_en", 32'(rd_en), 32'd0);
    chk("midrst_rd_addr", rd_addr, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr", 32'(wr_active), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_hold_c%0d", c), {busy, done, wr_active, rd_en}, 32'd0);
    end
    run_nominal("after_reset", 1'b0, 1'b1);
    $display("tile midrst aborted at t=3");

    // Second start while busy is ignored.
    run_nominal("start_busy", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/rd_skew_control.md
RD_SKEW_CONTROL -- requirements
Module: rd_skew_control

Interface
REQ-001 Parameter N, default 16: systolic array dimension (lane count).
REQ-002 Parameter ADDR_W, default 8: per-lane read address width.
REQ-003 Parameter MAX_LEN, default 16: maximum vectors per tile.
REQ-004 Parameter WR_LAT, default N+1, legal range >= N: cycles from the first read cycle to the first wr_active cycle.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle request to begin a tile read.
REQ-008 base_addr  input  ADDR_W  first address of the tile; sampled with start.
REQ-009 len  input  $clog2(MAX_LEN)+1  vectors in the tile; sampled with start.
REQ-010 stall  input  1  freezes sequencing while high.
REQ-011 rd_en  output  N  per-lane memory read enable; bit i is lane i.
REQ-012 rd_addr  output  N*ADDR_W  per-lane address; lane i occupies bits [i*ADDR_W +: ADDR_W].
REQ-013 busy  output  1  high while a tile is in progress.
REQ-014 wr_active  output  1  enables the downstream write/output controller.
REQ-015 done  output  1  one-cycle pulse at tile completion.

Function
REQ-016 States: IDLE, RUN, DONE.
- IDLE -> RUN on start with len > 0.
- IDLE -> DONE on start with len == 0.
- RUN -> DONE after the last wr_active cycle.
- DONE -> IDLE unconditionally.
REQ-017 start is honoured only in IDLE; start in RUN or DONE is ignored and base_addr/len are not resampled.
REQ-018 Relative cycle t = 0 is the first cycle after the edge that sampled start. Internal counter t advances by 1 per non-stalled RUN cycle.
REQ-019 Counter width: $clog2(MAX_LEN+WR_LAT)+1 bits, never overflowing.
REQ-020 Lane i read enable: rd_en[i] = 1 iff i <= t <= i+len-1 and stall is low. This gives the diagonal skew: lane 0 leads, and each lane lags the previous one by one cycle.
REQ-021 Lane address while enabled: base + (t - i), modulo 2^ADDR_W (wrap, no saturation). A disabled, non-stalled lane drives 0.
REQ-022 rd_en and rd_addr are registered outputs, with no combinational path from inputs.
REQ-023 wr_active = 1 iff WR_LAT <= t <= WR_LAT+len-1 and stall is low.
REQ-024 The RUN phase ends at t = WR_LAT+len-1. done pulses at t = WR_LAT+len (DONE state), together with all-zero rd_en. busy is low from that cycle on.
REQ-025 busy is high in RUN, including stalled cycles, and low in IDLE and DONE.
REQ-026 Stall behaviour:
- t holds while stall is high.
- rd_en = 0 and wr_active = 0 during stalled cycles.
- rd_addr holds its last value.
- Sequencing resumes with the same t after stall drops.
REQ-027 stall in IDLE or DONE has no effect.
REQ-028 len > MAX_LEN is clamped to MAX_LEN.

Reset
REQ-029 When reset is low, asynchronously:
- rd_en = 0, rd_addr = 0, busy = 0, wr_active = 0, done = 0.
- t = 0 and state = IDLE.
- Latched base and len are cleared.
REQ-030 Reset asserted mid-tile aborts the tile; no done pulse is produced.
REQ-031 The first start is accepted on the first rising edge after reset deasserts.

Structure
REQ-032 A shared package holds the state enum (IDLE/RUN/DONE) and the counter-width function.
REQ-033 One sub-module, rd_skew_lane, computes a single lane's enable and address from t, lane index, base, len and stall. It is instantiated N times by a generate loop.

Verification
REQ-034 Nominal (N=4, ADDR_W=8, WR_LAT=5): start, base=0x40, len=4.
- rd_en at t=0..7: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
- At t=3, lane addresses (3..0) are 0x40, 0x41, 0x42, 0x43.
- wr_active is high at t=5..8; done pulses at t=9; busy is high at t=0..8.
REQ-035 Stall: same stimulus with stall high for 3 cycles starting at t=2.
- rd_en = 0000 and rd_addr holds during the stall.
- After the stall, rd_en = 0111 with lane 0 at 0x42.
- done arrives 3 cycles late.
REQ-036 Wrap: base=0xFE, len=4. Lane 0 addresses are 0xFE, 0xFF, 0x00, 0x01 at t=0..3.
REQ-037 Zero length: start with len=0.
- done pulses at t=0.
- rd_en and wr_active never assert; busy stays 0.
REQ-038 Reset mid-run: reset low at t=3 of the nominal tile.
- All outputs go to 0 immediately and stay at 0.
- A new start after release produces the full nominal sequence.
REQ-039 Start while busy: a second start at t=2 with base=0x80 is ignored. The sequence is unchanged and exactly one done pulse is produced.
